// File: rtl/debounce_edge_pkg.sv
// rtl/debounce_edge_pkg.sv - FSM state encoding and default timing constants for debounce_edge
package debounce_edge_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b11,
        WAIT_LO = 2'b10
    } state_t;

    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 1;
    localparam int DEFAULT_STABLE_CNT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// rtl/debounce_edge_sync_chain.sv - sync_chain: reset-to-0 flop chain bringing din into the clk domain
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - synchronise, debounce and edge-detect a raw button input
// fall strobe register exists only when DEBOUNCE_FALL_EN is defined; otherwise fall is tied to 0
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = DEFAULT_STABLE_CNT,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_q;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rise_q, rise_nxt;
`ifdef DEBOUNCE_FALL_EN
    logic             fall_q, fall_nxt;
`endif

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (sync_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE_LO;
            cnt    <= '0;
            rise_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rise_q <= rise_nxt;
        end
    end

    // cnt counts consecutive samples opposing the committed level; commit on sample STABLE_CNT+1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
`ifdef DEBOUNCE_FALL_EN
        fall_nxt  = 1'b0;
`endif
        case (state)
            IDLE_LO: begin
                if (sync_q) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync_q) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!sync_q) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (sync_q) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
`ifdef DEBOUNCE_FALL_EN
                    fall_nxt  = 1'b1;
`endif
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_FALL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_nxt;
        end
    end
    assign fall = fall_q;
`else
    assign fall = 1'b0;
`endif

    // high states share encoding bit 1, so level is a direct register decode
    assign level = (state == IDLE_HI) || (state == WAIT_LO);
    assign rise  = rise_q;

endmodule
